regfile_dump: RTL and testbench
===============================

// Module: regfile_dump
// PURPOSE
//  Read-side sequencer for the 32x32 MIPS register file. On Start, walks a register range
//  through one asynchronous read port (address out, data in) and streams each word out on a
//  valid/ready interface. Used for debug dump, state save and regfile self-test benches.
//  Sits beside the register file and owns one of its read ports while Busy is high.
// PARAMETERS
//  DATA_W   32  register word width
//  ADDR_W   5   register address width (depth = 2**ADDR_W = 32)
// PORTS
//  Clk           in   1       clock, all state updates on rising edge
//  Reset_n       in   1       asynchronous, active-low reset
//  Start         in   1       begin a dump; sampled only in IDLE
//  FirstReg      in   ADDR_W  first register of range; latched with Start
//  LastReg       in   ADDR_W  last register of range; latched with Start
//  ReadRegister  out  ADDR_W  address to register-file read port
//  ReadData      in   DATA_W  asynchronous read data from register file
//  DumpData      out  DATA_W  streamed word
//  DumpAddr      out  ADDR_W  register index of DumpData
//  DumpCksum     out  1       high when DumpData is the checksum word (macro only, else 0)
//  DumpValid     out  1       DumpData/DumpAddr/DumpCksum valid
//  DumpReady     in   1       sink accepts word when DumpValid && DumpReady at rising edge
//  Busy          out  1       high in every state except IDLE
//  Done          out  1       one-cycle pulse after final word accepted
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state IDLE; ReadRegister, DumpData, DumpAddr = 0;
//    DumpValid, DumpCksum, Busy, Done = 0; address counter and checksum cleared.
//    Reset mid-dump aborts immediately; no Done; partial stream is discarded by the sink.
//  - FSM: IDLE -> READ -> SEND -> (READ | CKSUM | DONE) -> IDLE.
//  - IDLE: Start=1 at edge latches FirstReg/LastReg, counter=FirstReg, -> READ.
//  - READ: ReadRegister=counter (combinational from counter); at edge capture ReadData into
//    DumpData, counter into DumpAddr, set DumpValid, -> SEND.
//  - SEND: DumpValid=1; DumpData/DumpAddr held stable until handshake. On DumpValid&&DumpReady:
//    counter==Last -> CKSUM (macro) or DONE; else counter=counter+1 (mod 32), -> READ.
//  - DONE: DumpValid=0, Done=1 for exactly this cycle, -> IDLE next edge.
//  - Throughput: one word per 2 cycles with DumpReady held high (one READ bubble per word).
//  - Latency: Start sampled at edge k -> first DumpValid high after edge k+1.
//  - Range wrap: FirstReg > LastReg wraps 31 -> 0; word count = ((Last-First) mod 32)+1.
//    FirstReg == LastReg dumps exactly one word.
//  - Start while Busy ignored; FirstReg/LastReg changes while Busy ignored.
//  - Register-file writes during a dump: each word reflects the regfile at its READ edge;
//    dump is not an atomic snapshot. Register 0 reads whatever the regfile returns (0).
//  - ReadRegister holds last address in SEND/DONE/CKSUM; returns to 0 only on reset.
// CONFIGURATION
//  REGDUMP_CHECKSUM_EN defined: running XOR of every accepted data word; after last data
//  handshake -> CKSUM: DumpData=XOR, DumpAddr=0, DumpCksum=1, DumpValid=1; held until
//  handshake, then -> DONE. Checksum cleared on Start.
//  Not defined: no CKSUM state, no XOR logic, DumpCksum tied 0, SEND -> DONE directly.
// TESTING
//  1 reg[i]=i*32'h01010101, First=0, Last=31, DumpReady=1 -> 32 words, DumpAddr 0..31,
//    word0=0, word31=32'h1F1F1F1F, DumpValid every other cycle, single Done pulse.
//  2 Same preload, DumpReady random 50% -> identical sequence; DumpData/DumpAddr never change
//    while DumpValid && !DumpReady.
//  3 First=30, Last=1 -> DumpAddr 30,31,0,1 then Done; First=Last=5 -> one word 32'h05050505.
//  4 Start pulsed again mid-dump with different range -> ignored, original range completes.
//  5 Reset_n low during word 10 of full dump -> outputs 0 same cycle; new Start dumps cleanly.
//  6 REGDUMP_CHECKSUM_EN, full dump of test-1 data -> 33rd word DumpCksum=1,
//    DumpData=32'h00000000 (XOR of i*32'h01010101, i=0..31); without macro -> 32 words only.

Source files
------------

// File: rtl/regfile_dump_if.sv
// ---------------------------------------------------------------------------
// regfile_dump_if
//   Valid/ready stream carrying register-file dump words from regfile_dump to
//   its sink.
//   Signals:
//     DumpData   streamed register word (or checksum word)
//     DumpAddr   register index of DumpData (0 for the checksum word)
//     DumpCksum  high when DumpData is the checksum word
//     DumpValid  DumpData/DumpAddr/DumpCksum valid
//     DumpReady  sink accepts the word when DumpValid && DumpReady at a rising edge
//   Modports:
//     master  the dump sequencer (drives the word, samples DumpReady)
//     slave   the sink (samples the word, drives DumpReady)
// ---------------------------------------------------------------------------
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] DumpData;
  logic [ADDR_W-1:0] DumpAddr;
  logic              DumpCksum;
  logic              DumpValid;
  logic              DumpReady;

  modport master (
    output DumpData,
    output DumpAddr,
    output DumpCksum,
    output DumpValid,
    input  DumpReady
  );

  modport slave (
    input  DumpData,
    input  DumpAddr,
    input  DumpCksum,
    input  DumpValid,
    output DumpReady
  );
endinterface

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//   Read-side sequencer for the 32x32 MIPS register file. On Start it walks
//   the register range FirstReg..LastReg (wrapping 31 -> 0) through one
//   asynchronous read port and streams each word out on a valid/ready
//   interface. One word per two cycles when the sink is always ready.
//
//   Optional feature: define REGDUMP_CHECKSUM_EN to append a checksum word
//   (running XOR of every accepted data word, DumpAddr = 0, DumpCksum = 1)
//   after the last data word. Without it DumpCksum is tied low.
//
//   Ports:
//     Clk           clock, rising edge
//     Reset_n       asynchronous active-low reset
//     Start         begin a dump (sampled only in IDLE)
//     FirstReg      first register of the range, latched with Start
//     LastReg       last register of the range, latched with Start
//     ReadRegister  address to the register-file read port
//     ReadData      asynchronous read data from the register file
//     Busy          high whenever the sequencer is not IDLE
//     Done          one-cycle pulse after the final word is accepted
//     dumpIf        output stream (master side of regfile_dump_if)
// ---------------------------------------------------------------------------
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] FirstReg,
  input  logic [ADDR_W-1:0] LastReg,
  output logic [ADDR_W-1:0] ReadRegister,
  input  logic [DATA_W-1:0] ReadData,
  output logic              Busy,
  output logic              Done,
  regfile_dump_if.master    dumpIf
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
`ifdef REGDUMP_CHECKSUM_EN
  localparam logic [2:0] CKSUM = 3'd4;
`endif

  logic [2:0]        stateReg;
  logic [ADDR_W-1:0] counterReg;   // register currently being read / sent
  logic [ADDR_W-1:0] lastRegReg;   // end of range, frozen for the whole dump
  logic [DATA_W-1:0] dumpDataReg;
  logic [ADDR_W-1:0] dumpAddrReg;
  logic              handshake;
  logic              atLast;

  assign handshake = dumpIf.DumpValid && dumpIf.DumpReady;
  assign atLast    = (counterReg == lastRegReg);

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksumReg;
  logic              cksumFlagReg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateReg     <= IDLE;
      counterReg   <= '0;
      lastRegReg   <= '0;
      dumpDataReg  <= '0;
      dumpAddrReg  <= '0;
      checksumReg  <= '0;
      cksumFlagReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (Start) begin
            counterReg  <= FirstReg;
            lastRegReg  <= LastReg;
            checksumReg <= '0;
            stateReg    <= READ;
          end
        end
        READ: begin
          dumpDataReg <= ReadData;
          dumpAddrReg <= counterReg;
          stateReg    <= SEND;
        end
        SEND: begin
          if (handshake) begin
            checksumReg <= checksumReg ^ dumpDataReg;
            if (atLast) begin
              // Fold the word just accepted into the checksum word directly,
              // since checksumReg only updates at this same edge.
              dumpDataReg  <= checksumReg ^ dumpDataReg;
              dumpAddrReg  <= '0;
              cksumFlagReg <= 1'b1;
              stateReg     <= CKSUM;
            end else begin
              counterReg <= counterReg + 1'b1;
              stateReg   <= READ;
            end
          end
        end
        CKSUM: begin
          if (handshake) begin
            cksumFlagReg <= 1'b0;
            stateReg     <= DONE;
          end
        end
        DONE:    stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign dumpIf.DumpValid = (stateReg == SEND) || (stateReg == CKSUM);
  assign dumpIf.DumpCksum = cksumFlagReg;
`else
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateReg    <= IDLE;
      counterReg  <= '0;
      lastRegReg  <= '0;
      dumpDataReg <= '0;
      dumpAddrReg <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (Start) begin
            counterReg <= FirstReg;
            lastRegReg <= LastReg;
            stateReg   <= READ;
          end
        end
        READ: begin
          dumpDataReg <= ReadData;
          dumpAddrReg <= counterReg;
          stateReg    <= SEND;
        end
        SEND: begin
          if (handshake) begin
            if (atLast) begin
              stateReg <= DONE;
            end else begin
              counterReg <= counterReg + 1'b1;
              stateReg   <= READ;
            end
          end
        end
        DONE:    stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign dumpIf.DumpValid = (stateReg == SEND);
  assign dumpIf.DumpCksum = 1'b0;
`endif

  // The counter is never advanced past the last register, so the read port
  // keeps presenting the final address until the next dump or a reset.
  assign ReadRegister    = counterReg;
  assign dumpIf.DumpData = dumpDataReg;
  assign dumpIf.DumpAddr = dumpAddrReg;
  assign Busy            = (stateReg != IDLE);
  assign Done            = (stateReg == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [4:0]  FirstReg;
  logic [4:0]  LastReg;
  logic [4:0]  ReadRegister;
  logic [31:0] ReadData;
  logic        Busy;
  logic        Done;

  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) dumpIf ();

  regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .FirstReg     (FirstReg),
    .LastReg      (LastReg),
    .ReadRegister (ReadRegister),
    .ReadData     (ReadData),
    .Busy         (Busy),
    .Done         (Done),
    .dumpIf       (dumpIf)
  );

  // Register-file model: asynchronous read
  logic [31:0] rf [32];
  assign ReadData = rf[ReadRegister];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int nCompared   = 0;
  int nMismatched = 0;

  // Scoreboard entries: {cksum, addr, data}
  logic [37:0] expQ [$];

  int  doneCount;
  int  doneCyc;
  int  popped;
  int  startCyc;
  int  firstValidCyc;
  bit  firstValidSeen;
  bit  prevStall;
  logic [37:0] prevWord;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge Clk) begin
    logic [37:0] word;
    logic [37:0] expWord;
    if (!Reset_n) begin
      prevStall = 1'b0;
    end else begin
      word = {dumpIf.DumpCksum, dumpIf.DumpAddr, dumpIf.DumpData};
      if (prevStall)
        check("hold_while_stalled", {25'd0, dumpIf.DumpValid, word}, {25'd0, 1'b1, prevWord});
      if (dumpIf.DumpValid && !firstValidSeen) begin
        firstValidSeen = 1'b1;
        firstValidCyc  = cyc;
      end
      if (dumpIf.DumpValid && dumpIf.DumpReady) begin
        nCompared++;
        assert (expQ.size() != 0) else begin
          nMismatched++;
          $error("FAIL unexpected_word: observed %0h expected none", word);
        end
        if (expQ.size() != 0) begin
          expWord = expQ.pop_front();
          check("stream_word", {26'd0, word}, {26'd0, expWord});
        end
        popped++;
      end
      if (Done) begin
        doneCount++;
        doneCyc = cyc;
      end
      prevStall = dumpIf.DumpValid && !dumpIf.DumpReady;
      prevWord  = word;
    end
  end

  task automatic runDump(input int first, input int last, input bit randReady,
                         input int glitchCyc, input int abortWords, output bit aborted);
    int          n;
    int          cks;
    logic [31:0] x;
    logic [4:0]  a;
    n   = ((last - first) % 32 + 32) % 32 + 1;
    cks = 0;
    x   = '0;
    for (int i = 0; i < n; i++) begin
      a = 5'((first + i) % 32);
      expQ.push_back({1'b0, a, rf[a]});
      x ^= rf[a];
    end
`ifdef REGDUMP_CHECKSUM_EN
    expQ.push_back({1'b1, 5'd0, x});
    cks = 1;
`endif
    doneCount      = 0;
    popped         = 0;
    firstValidSeen = 1'b0;
    aborted        = 1'b0;
    @(posedge Clk); #1;
    Start    = 1'b1;
    FirstReg = 5'(first);
    LastReg  = 5'(last);
    dumpIf.DumpReady = 1'b1;
    @(posedge Clk); #1;
    startCyc = cyc;
    Start    = 1'b0;
    FirstReg = 5'($urandom);
    LastReg  = 5'($urandom);
    for (int c = 0; c < 400 && doneCount == 0; c++) begin
      if (abortWords > 0 && popped >= abortWords) begin
        aborted = 1'b1;
        break;
      end
      if (c == glitchCyc) begin
        Start    = 1'b1;
        FirstReg = 5'd7;
        LastReg  = 5'd9;
      end else begin
        Start = 1'b0;
      end
      dumpIf.DumpReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge Clk); #1;
    end
    Start = 1'b0;
    if (aborted) return;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    check("done_pulse_count", doneCount, 1);
    check("queue_drained", expQ.size(), 0);
    check("idle_after_dump", Busy, 0);
    check("readreg_holds_last", ReadRegister, last);
    if (!randReady) begin
      check("first_valid_latency", firstValidCyc - startCyc, 1);
      check("done_cycle", doneCyc - startCyc, 2 * n + cks);
    end
    expQ.delete();
  endtask

  initial begin
    bit ab;
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h01010101;
    Reset_n          = 1'b0;
    Start            = 1'b0;
    FirstReg         = 5'd0;
    LastReg          = 5'd0;
    dumpIf.DumpReady = 1'b0;
    prevStall        = 1'b0;
    doneCount        = 0;
    popped           = 0;
    firstValidSeen   = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_valid", dumpIf.DumpValid, 0);
    check("rst_data", dumpIf.DumpData, 0);
    check("rst_addr", dumpIf.DumpAddr, 0);
    check("rst_cksum", dumpIf.DumpCksum, 0);
    check("rst_readreg", ReadRegister, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // 1: full dump, sink always ready
    runDump(0, 31, 1'b0, -1, 0, ab);
    $display("step 1 full dump ready=1 done, compared=%0d", nCompared);
    // 2: full dump, random backpressure
    runDump(0, 31, 1'b1, -1, 0, ab);
    $display("step 2 full dump random ready done, compared=%0d", nCompared);
    // 3: wrapping range and single-word range
    runDump(30, 1, 1'b0, -1, 0, ab);
    $display("step 3a range 30..1 done, compared=%0d", nCompared);
    runDump(5, 5, 1'b0, -1, 0, ab);
    $display("step 3b range 5..5 done, compared=%0d", nCompared);
    // 4: Start re-pulsed mid-dump with another range must be ignored
    runDump(10, 14, 1'b0, 3, 0, ab);
    $display("step 4 mid-dump Start ignored, compared=%0d", nCompared);

    // 5: reset during word 10 of a full dump
    runDump(0, 31, 1'b0, -1, 10, ab);
    check("abort_reached", ab, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("abort_valid", dumpIf.DumpValid, 0);
    check("abort_data", dumpIf.DumpData, 0);
    check("abort_addr", dumpIf.DumpAddr, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_readreg", ReadRegister, 0);
    expQ.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    runDump(3, 6, 1'b0, -1, 0, ab);
    $display("step 5 reset mid-dump and clean restart, compared=%0d", nCompared);

    // Random-ready wrapped range with a writable register file changed between dumps
    rf[31] = 32'hDEADBEEF;
    rf[2]  = 32'h12345678;
    runDump(29, 3, 1'b1, -1, 0, ab);
    $display("step 6 wrapped random-ready dump done, compared=%0d", nCompared);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
